demux32_8_reg: RTL and testbench
================================

# demux32_8_reg

Registered 1-to-8 distributor for 32-bit words, the counterpart of the 8-to-1 result-select path in the multdiv datapath. A producer presents a word with a 3-bit destination select under a valid/ready handshake. The block latches the word into one of eight holding slots and raises that slot's valid flag. Each slot's consumer drains it independently with a one-cycle ack.

## Interface
Parameters:
- WIDTH, 32, data width of the input word and of each slot.

Ports:
- clock  in  1  rising-edge clock, the only clock.
- reset_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  producer presents in_data/select this cycle.
- in_ready  out  1  the slot addressed by select is empty.
- select  in  3  destination slot index 0..7.
- in_data  in  WIDTH  word to deliver.
- out_data  out  8*WIDTH  slot k occupies bits [k*WIDTH +: WIDTH].
- out_valid  out  8  bit k set while slot k holds an undrained word.
- out_ack  in  8  bit k drains slot k.
- occupancy  out  4  number of set out_valid bits, 0..8.
- drop_err  out  1  sticky flag: in_valid asserted while in_ready low.

## Operation
- Accept condition: in_valid && in_ready, where in_ready = ~out_valid[select].
  - in_ready is combinational from select and the registered out_valid only.
  - There is no path from out_ack to in_ready.
- On accept:
  - slot[select] <= in_data.
  - out_valid[select] <= 1.
- Drain: when out_ack[k] && out_valid[k], out_valid[k] <= 0.
  - out_data slot k keeps its last value; data is never cleared by a drain.
  - out_ack[k] on an empty slot is ignored.
- Simultaneous events:
  - An accept into slot j and acks on other slots in the same cycle all take effect.
  - An accept and an ack on the same slot cannot coincide, because in_ready is low for a full slot. The ack wins, and the producer's retry is accepted next cycle.
- in_data and select are sampled only on accept; their values are don't-care otherwise.
- occupancy is a registered counter:
  - next = occupancy + (accept ? 1 : 0) − (number of effective drains).
  - It always equals popcount(out_valid). It never exceeds 8 or goes below 0.
- drop_err:
  - Set on any cycle with in_valid=1 and in_ready=0.
  - Cleared only by reset.
  - It is a diagnostic; the producer is expected to hold in_valid until accepted, so a stall also sets it.
- Reset (reset_n low, asynchronous, any time including mid-transfer):
  - out_valid = 0, out_data = 0, occupancy = 0, drop_err = 0.
  - in_ready then reads 1 for every select.
  - An in-flight accept in the reset cycle is discarded.

## Timing
- Latency is 1 cycle: a word accepted at edge N is visible on out_data/out_valid after edge N.
- Drain: out_ack[k] high at edge N clears out_valid[k] after edge N.
  - A new accept into slot k is possible at edge N+1, so a slot supports back-to-back use every 2 cycles.
- Throughput: one accept per cycle when successive selects target empty slots.
- Reset release: the first accept is possible at the first rising edge with reset_n high.
- All outputs except in_ready are registered. in_ready has a combinational path from select only.

## Test plan
- Reset, then one accept (select=3, in_data=0xDEADBEEF):
  - Before the edge: in_ready=1.
  - After the edge: out_valid=8'b0000_1000, slot 3=0xDEADBEEF, occupancy=1.
- Fill all slots with in_data=0x100+k over 8 consecutive cycles:
  - out_valid=8'hFF, occupancy=8.
  - A 9th request to select=5 gives in_ready=0, slot 5 unchanged at 0x105, drop_err=1.
- Slot 2 full, out_ack[2]=1 and in_valid with select=2, in_data=0xAAAA in the same cycle:
  - The ack clears out_valid[2] and the word is not accepted.
  - Holding in_valid one more cycle accepts it: slot 2=0xAAAA, occupancy unchanged overall.
- Same cycle: accept to slot 0 plus out_ack=8'b1100_0000 with slots 6 and 7 full (occupancy 2) -> occupancy=1, out_valid=8'b0000_0001.
- Ack on an empty slot (out_ack[4]=1, out_valid[4]=0) -> no change to out_valid or occupancy, no underflow.
- reset_n pulsed low mid-cycle while occupancy=5 and an accept is pending -> all outputs 0 immediately; after release, occupancy=0 and drop_err=0.

Source files
------------

// File: rtl/demux32_8_reg.sv
// Registered 1-to-8 distributor: a producer delivers a word into one of eight
// holding slots under valid/ready; each slot is drained independently by its ack.
module demux32_8_reg #(
    parameter int WIDTH = 32
) (
    input  logic                 clock,
    input  logic                 reset_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [2:0]           select,
    input  logic [WIDTH-1:0]     in_data,
    output logic [8*WIDTH-1:0]   out_data,
    output logic [7:0]           out_valid,
    input  logic [7:0]           out_ack,
    output logic [3:0]           occupancy,
    output logic                 drop_err
);

    logic [7:0] valid_q, valid_d;
    logic [3:0] occ_q, occ_d;
    logic       drop_q, drop_d;
    logic       accept;
    logic [7:0] sel_onehot;
    logic [7:0] drains;
    logic [3:0] n_drain;

    // Ready depends only on registered slot state, never on out_ack.
    assign in_ready = ~valid_q[select];

    always_comb begin
        accept     = in_valid & in_ready;
        sel_onehot = 8'b0000_0001 << select;
        drains     = out_ack & valid_q;
        n_drain    = 4'd0;
        for (int i = 0; i < 8; i++) begin
            n_drain = n_drain + {3'b000, drains[i]};
        end
        valid_d = (valid_q & ~drains) | (accept ? sel_onehot : 8'h00);
        occ_d   = occ_q + {3'b000, accept} - n_drain;
        drop_d  = drop_q | (in_valid & ~in_ready);
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            valid_q <= 8'h00;
            occ_q   <= 4'd0;
            drop_q  <= 1'b0;
        end else begin
            valid_q <= valid_d;
            occ_q   <= occ_d;
            drop_q  <= drop_d;
        end
    end

    genvar gi;
    generate
        for (gi = 0; gi < 8; gi++) begin : g_slot
            logic [WIDTH-1:0] slot_q, slot_d;

            // Data is retained across drains; only an accept overwrites it.
            always_comb begin
                slot_d = slot_q;
                if (accept && (select == 3'(gi))) begin
                    slot_d = in_data;
                end
            end

            always_ff @(posedge clock or negedge reset_n) begin
                if (!reset_n) begin
                    slot_q <= '0;
                end else begin
                    slot_q <= slot_d;
                end
            end

            assign out_data[gi*WIDTH +: WIDTH] = slot_q;
        end
    endgenerate

    assign out_valid = valid_q;
    assign occupancy = occ_q;
    assign drop_err  = drop_q;

endmodule

// File: tb/tb_demux32_8_reg.sv
// Directed bench for demux32_8_reg: hand-computed expectations for accept,
// fill/overflow, same-cycle ack/accept, empty-slot ack and asynchronous reset.
module tb_demux32_8_reg;

    localparam int WIDTH = 32;

    logic               clock;
    logic               reset_n;
    logic               in_valid;
    logic               in_ready;
    logic [2:0]         select;
    logic [WIDTH-1:0]   in_data;
    logic [8*WIDTH-1:0] out_data;
    logic [7:0]         out_valid;
    logic [7:0]         out_ack;
    logic [3:0]         occupancy;
    logic               drop_err;

    int n_cmp = 0;
    int n_bad = 0;

    demux32_8_reg #(.WIDTH(WIDTH)) dut (
        .clock     (clock),
        .reset_n   (reset_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .select    (select),
        .in_data   (in_data),
        .out_data  (out_data),
        .out_valid (out_valid),
        .out_ack   (out_ack),
        .occupancy (occupancy),
        .drop_err  (drop_err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        n_cmp++;
        if (obs !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end else begin
            $display("ok   %s: %0h", tag, obs);
        end
    endtask

    function automatic logic [WIDTH-1:0] slot(input int k);
        return out_data[k*WIDTH +: WIDTH];
    endfunction

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    initial begin
        reset_n  = 1'b0;
        in_valid = 1'b0;
        select   = 3'd0;
        in_data  = '0;
        out_ack  = 8'h00;
        #12;
        chk("rst_valid", 64'(out_valid), 64'h00);
        chk("rst_occ",   64'(occupancy), 64'd0);
        chk("rst_drop",  64'(drop_err),  64'd0);
        chk("rst_data",  64'(out_data == '0), 64'd1);
        @(negedge clock);
        reset_n = 1'b1;

        // Single accept into slot 3.
        in_valid = 1'b1; select = 3'd3; in_data = 32'hDEADBEEF;
        #1 chk("acc_ready", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("acc_valid", 64'(out_valid), 64'h08);
        chk("acc_slot3", 64'(slot(3)), 64'hDEADBEEF);
        chk("acc_occ",   64'(occupancy), 64'd1);

        // Drain slot 3; data must persist.
        out_ack = 8'h08;
        step();
        out_ack = 8'h00;
        chk("drn_valid", 64'(out_valid), 64'h00);
        chk("drn_occ",   64'(occupancy), 64'd0);
        chk("drn_keep",  64'(slot(3)), 64'hDEADBEEF);

        // Fill all eight slots, one per cycle.
        for (int k = 0; k < 8; k++) begin
            in_valid = 1'b1; select = 3'(k); in_data = 32'h100 + 32'(k);
            step();
        end
        in_valid = 1'b0;
        chk("fill_valid", 64'(out_valid), 64'hFF);
        chk("fill_occ",   64'(occupancy), 64'd8);
        chk("fill_drop0", 64'(drop_err),  64'd0);
        chk("fill_slot7", 64'(slot(7)),   64'h107);

        // 9th request into full slot 5 is refused and flagged.
        in_valid = 1'b1; select = 3'd5; in_data = 32'h999;
        #1 chk("ovf_ready", 64'(in_ready), 64'd0);
        step();
        in_valid = 1'b0;
        chk("ovf_slot5", 64'(slot(5)),   64'h105);
        chk("ovf_drop",  64'(drop_err),  64'd1);
        chk("ovf_occ",   64'(occupancy), 64'd8);

        // Ack and accept on slot 2 in the same cycle: ack wins, retry next cycle.
        out_ack = 8'h04; in_valid = 1'b1; select = 3'd2; in_data = 32'hAAAA;
        #1 chk("same_ready0", 64'(in_ready), 64'd0);
        step();
        out_ack = 8'h00;
        chk("same_valid", 64'(out_valid), 64'hFB);
        chk("same_slot2", 64'(slot(2)),   64'h102);
        chk("same_occ",   64'(occupancy), 64'd7);
        chk("same_ready1", 64'(in_ready), 64'd1);
        step();
        in_valid = 1'b0;
        chk("retry_slot2", 64'(slot(2)),   64'hAAAA);
        chk("retry_occ",   64'(occupancy), 64'd8);
        chk("retry_valid", 64'(out_valid), 64'hFF);

        // Leave only slots 6 and 7 full.
        out_ack = 8'h3F;
        step();
        out_ack = 8'h00;
        chk("keep67_valid", 64'(out_valid), 64'hC0);
        chk("keep67_occ",   64'(occupancy), 64'd2);

        // Accept into slot 0 while draining 6 and 7.
        in_valid = 1'b1; select = 3'd0; in_data = 32'h55; out_ack = 8'hC0;
        step();
        in_valid = 1'b0; out_ack = 8'h00;
        chk("mix_occ",   64'(occupancy), 64'd1);
        chk("mix_valid", 64'(out_valid), 64'h01);
        chk("mix_slot0", 64'(slot(0)),   64'h55);

        // Ack on an empty slot is ignored.
        out_ack = 8'h10;
        step();
        out_ack = 8'h00;
        chk("empty_valid", 64'(out_valid), 64'h01);
        chk("empty_occ",   64'(occupancy), 64'd1);

        // Bring occupancy to 5 (slots 0..4).
        for (int k = 1; k < 5; k++) begin
            in_valid = 1'b1; select = 3'(k); in_data = 32'h200 + 32'(k);
            step();
        end
        in_valid = 1'b0;
        chk("pre_occ",   64'(occupancy), 64'd5);
        chk("pre_valid", 64'(out_valid), 64'h1F);

        // Asynchronous reset mid-cycle with an accept pending.
        in_valid = 1'b1; select = 3'd5; in_data = 32'h777;
        #3 reset_n = 1'b0;
        #1;
        chk("arst_valid", 64'(out_valid), 64'h00);
        chk("arst_occ",   64'(occupancy), 64'd0);
        chk("arst_drop",  64'(drop_err),  64'd0);
        chk("arst_data",  64'(out_data == '0), 64'd1);
        chk("arst_ready", 64'(in_ready),  64'd1);
        @(negedge clock);
        reset_n = 1'b1;
        in_valid = 1'b0;
        step();
        chk("post_occ",   64'(occupancy), 64'd0);
        chk("post_drop",  64'(drop_err),  64'd0);
        chk("post_valid", 64'(out_valid), 64'h00);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
